// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared CPU definitions used by the ID/EX pipeline register and the
//   EX-stage ALU control decoder:
//     - XLEN          : operand / immediate / PC width
//     - ALUOp         : main-decoder ALU operation class (aluop_e)
//     - ALU control   : EX-stage ALU function codes (aluctl_e)
//     - CTRL_*        : bit positions inside the 7-bit control bundle
//                       {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,ALUOp[1:0]}
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 7;

  localparam int CTRL_REGWRITE = 6;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_ALUSRC   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  typedef enum logic [1:0] {
    ALUOP_LDST  = 2'b00,
    ALUOP_BRCH  = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } aluop_e;

  typedef enum logic [2:0] {
    ALUC_AND  = 3'b000,
    ALUC_XOR  = 3'b001,
    ALUC_SLL  = 3'b010,
    ALUC_ADD  = 3'b011,
    ALUC_SUB  = 3'b100,
    ALUC_MUL  = 3'b101,
    ALUC_ADDI = 3'b110,
    ALUC_SRAI = 3'b111
  } aluctl_e;

  // True when the control bundle describes a load (result only available
  // after MEM, so a dependent instruction directly behind it must wait).
  function automatic logic ctrlIsLoad(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEMREAD];
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
//   Purely combinational load-use hazard detector. Raises o_hazard when the
//   instruction sitting in EX is a load whose destination is read by the
//   instruction currently in ID.
//   Ports:
//     i_stall       global memory stall; nothing moves, so no hold request
//     i_id_valid    ID holds a real instruction
//     i_id_rs1/rs2  ID source register addresses
//     i_ex_valid    EX holds a real instruction
//     i_ex_memread  EX instruction is a load
//     i_ex_rd       EX destination register address
//     o_hazard      hold request for PC and IF/ID
// ---------------------------------------------------------------------------
module load_use_detect (
  input  logic       i_stall,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_ex_valid,
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rd,
  output logic       o_hazard
);

  logic w_load_in_ex;
  logic w_src_match;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign w_load_in_ex = i_ex_valid & i_ex_memread & (i_ex_rd != 5'd0);
  assign w_src_match  = (i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2);
  assign o_hazard     = ~i_stall & i_id_valid & w_load_in_ex & w_src_match;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
//   ID/EX pipeline register in front of the ALU-control decoder and ALU.
//   Inserts bubbles for load-use hazards and branch flushes, freezes on a
//   global memory stall, and remembers a flush seen during a stall so it is
//   applied on the first unstalled edge. Two saturating counters track
//   inserted bubbles and stalled cycles.
//   Ports:
//     clk_i, rst_i         clock, synchronous active-high reset
//     start_i              run enable; 0 freezes all state
//     stall_i, flush_i     memory stall, branch-taken flush
//     id_*_i               decoded ID-stage instruction fields
//     ex_*_o               registered EX-stage instruction fields
//     hazard_o             combinational load-use hold request
//     bubble_cnt_o         bubbles inserted (load-use or flush)
//     stall_cnt_o          cycles spent stalled while running
// ---------------------------------------------------------------------------
module id_ex_pipe_reg
  import cpu_pkg::*;
#(
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [XLEN-1:0]   id_rs1data_i,
  input  logic [XLEN-1:0]   id_rs2data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [9:0]        id_funct_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic [4:0]        id_rd_i,
  input  logic [XLEN-1:0]   id_pc_i,
  output logic              ex_valid_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [XLEN-1:0]   ex_rs1data_o,
  output logic [XLEN-1:0]   ex_rs2data_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [9:0]        ex_funct_o,
  output logic [4:0]        ex_rs1_o,
  output logic [4:0]        ex_rs2_o,
  output logic [4:0]        ex_rd_o,
  output logic              hazard_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [XLEN-1:0]   r_rs1data;
  logic [XLEN-1:0]   r_rs2data;
  logic [XLEN-1:0]   r_imm;
  logic [XLEN-1:0]   r_pc;
  logic [9:0]        r_funct;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic              r_flush_pend;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_hazard;
  logic              w_flush_now;
  logic              w_bubble_sat;
  logic              w_stall_sat;

  load_use_detect u_load_use_detect (
    .i_stall      (stall_i),
    .i_id_valid   (id_valid_i),
    .i_id_rs1     (id_rs1_i),
    .i_id_rs2     (id_rs2_i),
    .i_ex_valid   (r_valid),
    .i_ex_memread (ctrlIsLoad(r_ctrl)),
    .i_ex_rd      (r_rd),
    .o_hazard     (w_hazard)
  );

  assign w_flush_now  = flush_i | r_flush_pend;
  assign w_bubble_sat = &r_bubble_cnt;
  assign w_stall_sat  = &r_stall_cnt;

  // Priority: reset > stall (hold, remember flush) > flush > load-use > capture.
  // A bubble zeroes valid, control and register addresses so it can neither
  // write state nor trigger forwarding/hazard logic; the data fields are left
  // as they were since nothing downstream looks at them without valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_rs1data    <= '0;
      r_rs2data    <= '0;
      r_imm        <= '0;
      r_pc         <= '0;
      r_funct      <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_flush_pend <= 1'b0;
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else if (start_i) begin
      if (stall_i) begin
        if (flush_i) begin
          r_flush_pend <= 1'b1;
        end
        if (!w_stall_sat) begin
          r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
      end else if (w_flush_now || w_hazard) begin
        r_valid      <= 1'b0;
        r_ctrl       <= '0;
        r_rs1        <= '0;
        r_rs2        <= '0;
        r_rd         <= '0;
        r_flush_pend <= 1'b0;
        if (!w_bubble_sat) begin
          r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
      end else begin
        r_valid   <= id_valid_i;
        r_ctrl    <= id_ctrl_i;
        r_rs1data <= id_rs1data_i;
        r_rs2data <= id_rs2data_i;
        r_imm     <= id_imm_i;
        r_pc      <= id_pc_i;
        r_funct   <= id_funct_i;
        r_rs1     <= id_rs1_i;
        r_rs2     <= id_rs2_i;
        r_rd      <= id_rd_i;
      end
    end
  end

  assign ex_valid_o   = r_valid;
  assign ex_ctrl_o    = r_ctrl;
  assign ex_rs1data_o = r_rs1data;
  assign ex_rs2data_o = r_rs2data;
  assign ex_imm_o     = r_imm;
  assign ex_pc_o      = r_pc;
  assign ex_funct_o   = r_funct;
  assign ex_rs1_o     = r_rs1;
  assign ex_rs2_o     = r_rs2;
  assign ex_rd_o      = r_rd;
  assign hazard_o     = w_hazard;
  assign bubble_cnt_o = r_bubble_cnt;
  assign stall_cnt_o  = r_stall_cnt;

endmodule
